// File: rtl/eeg_fram_pingpong.sv
// EEG feature RAM controller with per-channel ping/pong banks.
// One bank is written while the other feeds convolution or readout.
module eeg_fram_pingpong #(
  parameter int FRAM_CMD_DW = 4,
  parameter int FRAM_NUM_DW = 4,
  parameter int FRAM_ADD_AW = 12,
  parameter int FRAM_DEP_AW = 10,
  parameter int FRAM_DAT_DW = 4,
  parameter logic [FRAM_DAT_DW-1:0] FRAM_FIL_DAT = '1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  output logic                                   IS_IDLE,
  input  logic                                   CFG_INFO_VLD,
  output logic                                   CFG_INFO_RDY,
  input  logic [FRAM_CMD_DW-1:0]                 CFG_INFO_CMD,
  input  logic                                   CFG_FLAG_VLD,
  input  logic                                   CFG_BANK_SWP,
  input  logic [FRAM_NUM_DW-1:0]                 CFG_CHN_ENA,
  output logic                                   CFG_ERR,
  output logic                                   BANK_PTR,
  input  logic [FRAM_NUM_DW-1:0]                 ETOF_DAT_VLD,
  input  logic [FRAM_NUM_DW-1:0]                 ETOF_DAT_LST,
  output logic [FRAM_NUM_DW-1:0]                 ETOF_DAT_RDY,
  input  logic [FRAM_NUM_DW-1:0][FRAM_ADD_AW-1:0] ETOF_DAT_ADD,
  input  logic [FRAM_NUM_DW-1:0][FRAM_DAT_DW-1:0] ETOF_DAT_DAT,
  input  logic [FRAM_NUM_DW-1:0]                 ETOF_ADD_VLD,
  input  logic [FRAM_NUM_DW-1:0]                 ETOF_ADD_LST,
  input  logic [FRAM_NUM_DW-1:0]                 ETOF_ADD_END,
  output logic [FRAM_NUM_DW-1:0]                 ETOF_ADD_RDY,
  input  logic [FRAM_NUM_DW-1:0][FRAM_ADD_AW-1:0] ETOF_ADD_ADD,
  output logic [FRAM_NUM_DW-1:0]                 FTOE_DAT_VLD,
  output logic [FRAM_NUM_DW-1:0]                 FTOE_DAT_LST,
  input  logic [FRAM_NUM_DW-1:0]                 FTOE_DAT_RDY,
  output logic [FRAM_NUM_DW-1:0][FRAM_DAT_DW-1:0] FTOE_DAT_DAT
);

  localparam int N     = FRAM_NUM_DW;
  localparam int DEPTH = 1 << FRAM_DEP_AW;

  typedef enum logic [FRAM_CMD_DW-1:0] {
    IDLE = FRAM_CMD_DW'(1),
    ITOF = FRAM_CMD_DW'(2),
    CONV = FRAM_CMD_DW'(4),
    OTOF = FRAM_CMD_DW'(8)
  } state_t;

  state_t state, state_nxt;

  logic         flag_q;
  logic [N-1:0] mask_q;
  logic [N-1:0] done_q;
  logic [N-1:0] done_set;
  logic [N-1:0] wr_hs;
  logic [N-1:0] ad_hs;
  logic [N-1:0] od_hs;
  logic         cfg_ena;
  logic         cmd_ok;
  logic         all_done;
  logic         st_itof;
  logic         st_conv;
  logic         st_otof;
  logic         unused_add;

  logic [FRAM_DAT_DW-1:0] ram [N][2][DEPTH];

  assign IS_IDLE      = (state == IDLE);
  assign CFG_INFO_RDY = IS_IDLE;
  assign cfg_ena      = CFG_INFO_VLD & CFG_INFO_RDY;
  assign cmd_ok       = (CFG_INFO_CMD == ITOF) |
                        (CFG_INFO_CMD == CONV) |
                        (CFG_INFO_CMD == OTOF);
  assign st_itof      = (state == ITOF);
  assign st_conv      = (state == CONV);
  assign st_otof      = (state == OTOF);
  assign all_done     = &(done_q | ~mask_q);

  assign ETOF_DAT_RDY = {N{st_itof}} & mask_q & ~done_q;
  assign ETOF_ADD_RDY = {N{st_conv | st_otof}} & mask_q & ~done_q &
                        (~FTOE_DAT_VLD | FTOE_DAT_RDY);

  assign wr_hs = ETOF_DAT_VLD & ETOF_DAT_RDY;
  assign ad_hs = ETOF_ADD_VLD & ETOF_ADD_RDY;
  assign od_hs = FTOE_DAT_VLD & FTOE_DAT_RDY;

  assign done_set = ({N{st_itof}} & wr_hs & ETOF_DAT_LST) |
                    ({N{st_conv}} & ad_hs & ETOF_ADD_END) |
                    ({N{st_otof}} & od_hs & FTOE_DAT_LST);

  // address bits above the bank depth are deliberately dropped
  assign unused_add = &{1'b0, ETOF_DAT_ADD, ETOF_ADD_ADD};

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state[0]: if (cfg_ena && cmd_ok) state_nxt = state_t'(CFG_INFO_CMD);
      state[1], state[2], state[3]: if (all_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      flag_q   <= 1'b0;
      mask_q   <= '0;
      done_q   <= '0;
      BANK_PTR <= 1'b0;
      CFG_ERR  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cfg_ena) begin
        flag_q <= CFG_FLAG_VLD;
        mask_q <= CFG_CHN_ENA;
        done_q <= '0;
        if (CFG_BANK_SWP) BANK_PTR <= ~BANK_PTR;
        if (!cmd_ok)      CFG_ERR  <= 1'b1;
      end else begin
        done_q <= done_q | done_set;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (wr_hs[c])
        ram[c][BANK_PTR][ETOF_DAT_ADD[c][FRAM_DEP_AW-1:0]] <= ETOF_DAT_DAT[c];
    end
  end

  // one-deep output register per channel; reload wins over drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FTOE_DAT_VLD <= '0;
      FTOE_DAT_LST <= '0;
      FTOE_DAT_DAT <= '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (ad_hs[c]) begin
          FTOE_DAT_VLD[c] <= 1'b1;
          FTOE_DAT_LST[c] <= ETOF_ADD_LST[c];
          FTOE_DAT_DAT[c] <= flag_q ?
            ram[c][~BANK_PTR][ETOF_ADD_ADD[c][FRAM_DEP_AW-1:0]] :
            FRAM_FIL_DAT;
        end else if (od_hs[c]) begin
          FTOE_DAT_VLD[c] <= 1'b0;
          FTOE_DAT_LST[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_eeg_fram_pingpong.sv
// Randomized bench for eeg_fram_pingpong against a bank/queue
// reference model of the feature RAM.
module tb_eeg_fram_pingpong;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 4;

  localparam logic [3:0] C_ITOF = 4'b0010;
  localparam logic [3:0] C_CONV = 4'b0100;
  localparam logic [3:0] C_OTOF = 4'b1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic                 IS_IDLE;
  logic                 CFG_INFO_VLD;
  logic                 CFG_INFO_RDY;
  logic [3:0]           CFG_INFO_CMD;
  logic                 CFG_FLAG_VLD;
  logic                 CFG_BANK_SWP;
  logic [N-1:0]         CFG_CHN_ENA;
  logic                 CFG_ERR;
  logic                 BANK_PTR;
  logic [N-1:0]         ETOF_DAT_VLD;
  logic [N-1:0]         ETOF_DAT_LST;
  logic [N-1:0]         ETOF_DAT_RDY;
  logic [N-1:0][AW-1:0] ETOF_DAT_ADD;
  logic [N-1:0][DW-1:0] ETOF_DAT_DAT;
  logic [N-1:0]         ETOF_ADD_VLD;
  logic [N-1:0]         ETOF_ADD_LST;
  logic [N-1:0]         ETOF_ADD_END;
  logic [N-1:0]         ETOF_ADD_RDY;
  logic [N-1:0][AW-1:0] ETOF_ADD_ADD;
  logic [N-1:0]         FTOE_DAT_VLD;
  logic [N-1:0]         FTOE_DAT_LST;
  logic [N-1:0]         FTOE_DAT_RDY;
  logic [N-1:0][DW-1:0] FTOE_DAT_DAT;

  eeg_fram_pingpong dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IS_IDLE      (IS_IDLE),
    .CFG_INFO_VLD (CFG_INFO_VLD),
    .CFG_INFO_RDY (CFG_INFO_RDY),
    .CFG_INFO_CMD (CFG_INFO_CMD),
    .CFG_FLAG_VLD (CFG_FLAG_VLD),
    .CFG_BANK_SWP (CFG_BANK_SWP),
    .CFG_CHN_ENA  (CFG_CHN_ENA),
    .CFG_ERR      (CFG_ERR),
    .BANK_PTR     (BANK_PTR),
    .ETOF_DAT_VLD (ETOF_DAT_VLD),
    .ETOF_DAT_LST (ETOF_DAT_LST),
    .ETOF_DAT_RDY (ETOF_DAT_RDY),
    .ETOF_DAT_ADD (ETOF_DAT_ADD),
    .ETOF_DAT_DAT (ETOF_DAT_DAT),
    .ETOF_ADD_VLD (ETOF_ADD_VLD),
    .ETOF_ADD_LST (ETOF_ADD_LST),
    .ETOF_ADD_END (ETOF_ADD_END),
    .ETOF_ADD_RDY (ETOF_ADD_RDY),
    .ETOF_ADD_ADD (ETOF_ADD_ADD),
    .FTOE_DAT_VLD (FTOE_DAT_VLD),
    .FTOE_DAT_LST (FTOE_DAT_LST),
    .FTOE_DAT_RDY (FTOE_DAT_RDY),
    .FTOE_DAT_DAT (FTOE_DAT_DAT)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [DW-1:0] mem [N][2][1024];
  logic [9:0]    wlist [N][2][64];
  int            wcnt [N][2];
  logic          bank_m;
  logic          err_m;
  logic [N-1:0]  mask_m;
  logic [N-1:0]  done_m;
  logic          flag_m;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] cmd, input logic flag,
                     input logic swp, input logic [N-1:0] m);
    logic legal;
    legal = (cmd == C_ITOF) || (cmd == C_CONV) || (cmd == C_OTOF);
    chk("cfg_rdy", 32'(CFG_INFO_RDY), 32'd1);
    CFG_INFO_VLD = 1'b1;
    CFG_INFO_CMD = cmd;
    CFG_FLAG_VLD = flag;
    CFG_BANK_SWP = swp;
    CFG_CHN_ENA  = m;
    tick();
    CFG_INFO_VLD = 1'b0;
    if (swp) bank_m = ~bank_m;
    if (!legal) err_m = 1'b1;
    mask_m = m;
    flag_m = flag;
    done_m = '0;
    chk("bank_ptr", 32'(BANK_PTR), 32'(bank_m));
    chk("cfg_err", 32'(CFG_ERR), 32'(err_m));
    chk("cfg_state", 32'(IS_IDLE), 32'(!legal));
  endtask

  task automatic idle_exact();
    chk("idle_late", 32'(IS_IDLE), 32'd0);
    tick();
    chk("idle_back", 32'(IS_IDLE), 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!IS_IDLE && k < 8) begin
      tick();
      k++;
    end
    chk("wait_idle", 32'(IS_IDLE), 32'd1);
  endtask

  task automatic run_wr();
    int n, base, i;
    logic g;
    logic [9:0] lo;
    logic [DW-1:0] d;
    for (int c = 0; c < N; c++) begin
      if (!mask_m[c]) continue;
      n = $urandom_range(1, 6);
      base = $urandom_range(0, 1017);
      i = 0;
      while (i < n) begin
        g = ($urandom_range(0, 3) == 0);
        lo = 10'(base + i);
        d = DW'($urandom);
        ETOF_DAT_VLD = '0;
        ETOF_DAT_LST = '0;
        ETOF_DAT_VLD[c] = !g;
        ETOF_DAT_LST[c] = (i == n - 1);
        ETOF_DAT_ADD[c] = {2'($urandom), lo};
        ETOF_DAT_DAT[c] = d;
        #1;
        chk("wr_rdy", 32'(ETOF_DAT_RDY), 32'(mask_m & ~done_m));
        tick();
        if (!g) begin
          mem[c][bank_m][lo] = d;
          wlist[c][bank_m][wcnt[c][bank_m] % 64] = lo;
          wcnt[c][bank_m]++;
          if (i == n - 1) done_m[c] = 1'b1;
          i++;
        end
      end
      ETOF_DAT_VLD = '0;
      ETOF_DAT_LST = '0;
    end
  endtask

  function automatic logic [9:0] pick(input int c, input logic b);
    int lim;
    lim = (wcnt[c][b] > 64) ? 64 : wcnt[c][b];
    if (!flag_m || lim == 0) return 10'($urandom);
    return wlist[c][b][$urandom_range(0, lim - 1)];
  endfunction

  task automatic run_rd(input logic conv);
    logic rb, av, acc, con, qv, ql, dn;
    logic [DW-1:0] qd;
    logic [9:0] lo;
    logic [N-1:0] er, ev;
    int n, ai, cyc;
    rb = ~bank_m;
    for (int c = 0; c < N; c++) begin
      if (!mask_m[c]) continue;
      n = $urandom_range(1, 6);
      ai = 0;
      cyc = 0;
      dn = 1'b0;
      qv = 1'b0;
      ql = 1'b0;
      qd = '0;
      lo = pick(c, rb);
      while (!(dn && !qv)) begin
        av = (ai < n) && ($urandom_range(0, 3) != 0);
        ETOF_ADD_VLD = '0;
        ETOF_ADD_LST = '0;
        ETOF_ADD_END = '0;
        ETOF_ADD_VLD[c] = av;
        ETOF_ADD_LST[c] = (ai == n - 1);
        ETOF_ADD_END[c] = conv && (ai == n - 1);
        ETOF_ADD_ADD[c] = {2'($urandom), lo};
        FTOE_DAT_RDY = N'($urandom);
        FTOE_DAT_RDY[c] = ($urandom_range(0, 3) != 0);
        #1;
        ev = '0;
        ev[c] = qv;
        for (int k = 0; k < N; k++)
          er[k] = mask_m[k] & ~done_m[k] & (~ev[k] | FTOE_DAT_RDY[k]);
        chk("add_rdy", 32'(ETOF_ADD_RDY), 32'(er));
        chk("out_vld", 32'(FTOE_DAT_VLD), 32'(ev));
        if (qv) begin
          chk("out_dat", 32'(FTOE_DAT_DAT[c]), 32'(qd));
          chk("out_lst", 32'(FTOE_DAT_LST[c]), 32'(ql));
        end
        acc = av & er[c];
        con = qv & FTOE_DAT_RDY[c];
        tick();
        if (con) begin
          qv = 1'b0;
          if (ql && !conv) begin
            done_m[c] = 1'b1;
            dn = 1'b1;
          end
        end
        if (acc) begin
          qv = 1'b1;
          qd = flag_m ? mem[c][rb][lo] : {DW{1'b1}};
          ql = (ai == n - 1);
          if (conv && ql) begin
            done_m[c] = 1'b1;
            dn = 1'b1;
          end
          ai++;
          lo = pick(c, rb);
        end
        cyc++;
        if (cyc > 300) begin
          chk("rd_timeout", 32'(dn), 32'd1);
          break;
        end
      end
      ETOF_ADD_VLD = '0;
      ETOF_ADD_LST = '0;
      ETOF_ADD_END = '0;
      FTOE_DAT_RDY = '0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] m, avail;
    logic [3:0] ic;
    logic [3:0] ill [4];
    ill[0] = 4'b0011;
    ill[1] = 4'b0000;
    ill[2] = 4'b0001;
    ill[3] = 4'b1100;
    CFG_INFO_VLD = 0;
    CFG_INFO_CMD = '0;
    CFG_FLAG_VLD = 0;
    CFG_BANK_SWP = 0;
    CFG_CHN_ENA  = '0;
    ETOF_DAT_VLD = '0;
    ETOF_DAT_LST = '0;
    ETOF_DAT_ADD = '0;
    ETOF_DAT_DAT = '0;
    ETOF_ADD_VLD = '0;
    ETOF_ADD_LST = '0;
    ETOF_ADD_END = '0;
    ETOF_ADD_ADD = '0;
    FTOE_DAT_RDY = '0;
    bank_m = 0;
    err_m  = 0;
    mask_m = '0;
    done_m = '0;
    flag_m = 0;
    for (int c = 0; c < N; c++) begin
      wcnt[c][0] = 0;
      wcnt[c][1] = 0;
    end
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle", 32'(IS_IDLE), 32'd1);
    chk("rst_cfg_rdy", 32'(CFG_INFO_RDY), 32'd1);
    chk("rst_err", 32'(CFG_ERR), 32'd0);
    chk("rst_bank", 32'(BANK_PTR), 32'd0);
    chk("rst_wr_rdy", 32'(ETOF_DAT_RDY), 32'd0);
    chk("rst_add_rdy", 32'(ETOF_ADD_RDY), 32'd0);
    chk("rst_out_vld", 32'(FTOE_DAT_VLD), 32'd0);
    chk("rst_out_lst", 32'(FTOE_DAT_LST), 32'd0);
    chk("rst_out_dat", 32'(FTOE_DAT_DAT), 32'd0);
    rst_n = 1;
    tick();

    for (int r = 0; r < 10; r++) begin
      m = (r == 0) ? 4'hF : N'($urandom);
      cfg(C_ITOF, 1'b1, (r == 0) ? 1'b0 : 1'($urandom), m);
      if (m != 0) run_wr();
      idle_exact();

      for (int c = 0; c < N; c++) avail[c] = (wcnt[c][bank_m] > 0);
      m = (r == 0) ? 4'hF : (N'($urandom) & avail);
      cfg(C_OTOF, 1'b1, 1'b1, m);
      if (m != 0) run_rd(1'b0);
      idle_exact();

      m = N'($urandom);
      cfg(C_OTOF, 1'b0, 1'b0, m);
      if (m != 0) run_rd(1'b0);
      idle_exact();

      m = (r == 0) ? 4'b0101 : (N'($urandom) & avail);
      cfg(C_CONV, 1'b1, 1'b0, m);
      if (m == 0) idle_exact();
      else begin
        run_rd(1'b1);
        wait_idle();
      end

      ic = ill[r % 4];
      cfg(ic, 1'($urandom), 1'b0, N'($urandom));
    end

    cfg(C_OTOF, 1'b0, 1'b1, 4'b0001);
    ETOF_ADD_VLD[0] = 1'b1;
    FTOE_DAT_RDY = '0;
    #1;
    chk("mid_add_rdy", 32'(ETOF_ADD_RDY), 32'd1);
    tick();
    ETOF_ADD_VLD = '0;
    chk("mid_vld", 32'(FTOE_DAT_VLD), 32'd1);
    chk("mid_dat", 32'(FTOE_DAT_DAT[0]), 32'hF);
    #2;
    rst_n = 0;
    #1;
    chk("arst_vld", 32'(FTOE_DAT_VLD), 32'd0);
    chk("arst_idle", 32'(IS_IDLE), 32'd1);
    chk("arst_bank", 32'(BANK_PTR), 32'd0);
    chk("arst_err", 32'(CFG_ERR), 32'd0);
    tick();
    rst_n = 1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/eeg_fram_pingpong.md
Name: eeg_fram_pingpong

Overview:
- Multi-channel feature RAM controller for the EEG datapath; next generation of the single-bank feature RAM.
- Each channel has two banks (ping/pong), so one frame can be written while the previous frame is read for convolution or readout.
- Adds channel-enable masking, a parametrised fill value for flag-invalid frames, a sticky illegal-command error, and a command FSM whose completion is judged only over enabled channels.

Parameters:
- FRAM_CMD_DW, 4, command/state width (one-hot).
- FRAM_NUM_DW, 4, channel count.
- FRAM_ADD_AW, 12, external address width.
- FRAM_DEP_AW, 10, per-bank RAM address width (must be ≤ FRAM_ADD_AW); only the low FRAM_DEP_AW address bits are used.
- FRAM_DAT_DW, 4, data width.
- FRAM_FIL_DAT, all-ones, read value returned when the frame flag is invalid.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- IS_IDLE  out  1  FSM is in IDLE
- CFG_INFO_VLD  in  1  config valid
- CFG_INFO_RDY  out  1  config ready (= IS_IDLE)
- CFG_INFO_CMD  in  FRAM_CMD_DW  one-hot: 0010 ITOF, 0100 CONV, 1000 OTOF
- CFG_FLAG_VLD  in  1  frame data valid; 0 selects fill mode
- CFG_BANK_SWP  in  1  toggle bank pointer on accept
- CFG_CHN_ENA  in  FRAM_NUM_DW  channel enable mask
- CFG_ERR  out  1  sticky illegal-command flag
- BANK_PTR  out  1  current write bank
- ETOF_DAT_VLD/LST  in  FRAM_NUM_DW  write valid/last
- ETOF_DAT_RDY  out  FRAM_NUM_DW  write ready
- ETOF_DAT_ADD  in  FRAM_NUM_DW x FRAM_ADD_AW  write address
- ETOF_DAT_DAT  in  FRAM_NUM_DW x FRAM_DAT_DW  write data
- ETOF_ADD_VLD/LST/END  in  FRAM_NUM_DW  read-address valid/last/conv-end
- ETOF_ADD_RDY  out  FRAM_NUM_DW  read-address ready
- ETOF_ADD_ADD  in  FRAM_NUM_DW x FRAM_ADD_AW  read address
- FTOE_DAT_VLD/LST  out  FRAM_NUM_DW  read data valid/last
- FTOE_DAT_RDY  in  FRAM_NUM_DW  read data ready
- FTOE_DAT_DAT  out  FRAM_NUM_DW x FRAM_DAT_DW  read data

Behaviour:
- Reset values:
  - FSM = IDLE; IS_IDLE = 1; CFG_ERR = 0; BANK_PTR = 0.
  - Latched cmd/flag/mask = 0; all RDY = 0 except CFG_INFO_RDY = 1.
  - FTOE_DAT_VLD/LST = 0; FTOE_DAT_DAT = 0.
  - RAM contents are not reset.
- Config accept (cfg_ena = VLD & RDY):
  - Latch cmd, flag, and mask.
  - If SWP = 1, toggle BANK_PTR.
  - Clear all per-channel done bits.
- FSM states: IDLE, ITOF, CONV, OTOF.
  - IDLE -> CFG_INFO_CMD on cfg_ena if the cmd is exactly one of the three legal codes.
  - Otherwise stay in IDLE and set CFG_ERR; CFG_ERR clears only on reset.
  - ITOF -> IDLE when the AND over channels of (done | ~mask) is 1. Done is set by a write handshake with LST.
  - CONV -> IDLE on the same condition, with done set by ETOF_ADD_VLD & RDY & END.
  - OTOF -> IDLE on the same condition, with done set by FTOE_DAT_VLD & RDY & LST.
  - Transition to IDLE occurs the cycle after the last done bit sets.
  - All-zero mask: the state is entered, then returns to IDLE on the next cycle.
- Write path:
  - ETOF_DAT_RDY[c] = ITOF & mask[c] & ~done[c].
  - On handshake, RAM[c][BANK_PTR][ADD[FRAM_DEP_AW-1:0]] <= DAT.
  - Writes outside ITOF are never accepted.
- Read path (CONV or OTOF, per enabled channel, not done):
  - Reads target bank ~BANK_PTR.
  - ETOF_ADD_RDY[c] = active & (~FTOE_DAT_VLD[c] | FTOE_DAT_RDY[c]).
  - Address handshake → FTOE_DAT_VLD = 1 and LST = ADD_LST on the next cycle (latency 1).
  - DAT = RAM q when flag = 1, else FRAM_FIL_DAT; in fill mode the RAM is not read.
  - Data, VLD and LST hold stable while VLD & ~RDY.
  - Back-to-back address/data handshakes give full throughput of one per cycle.
  - VLD clears when consumed and no new address is accepted in the same cycle.
- Same-cycle events:
  - A data consume and a new address accept in the same cycle reload the output; VLD stays 1.
  - Done bit set and cfg_ena cannot coincide (RDY = IS_IDLE).
- Done-bit behaviour:
  - Once done[c] sets, that channel's RDY drops.
  - An output still pending in CONV drains normally after the FSM returns to IDLE.
- Address bits above FRAM_DEP_AW are ignored, so wrap-around is silent.
- Reset mid-operation: FSM to IDLE; VLD outputs drop asynchronously; bank pointer returns to 0.

Test Plan:
- Reset, then ITOF with SWP=0 and mask=1111; write addr 0..3 = 1,2,3,4 per channel with LST on addr 3 → IDLE after the last LST; IS_IDLE=1.
- Cmd OTOF with SWP=1 and flag=1; read addr 0..3 on channel 0 → DAT 1,2,3,4 one cycle after each address; LST on the 4th; IDLE after all four channels finish.
- Same OTOF with FTOE_DAT_RDY[0] low for 3 cycles mid-burst → DAT/VLD held; ADD_RDY[0]=0 while stalled; no data lost or duplicated.
- Flag=0 read, 4 beats → DAT=1111 each beat, LST on the 4th.
- CONV with mask=0101 and END on channels 0,2 only → IDLE; ADD_RDY[1,3]=0 throughout.
- Cmd 0011 → FSM stays IDLE, CFG_ERR=1; write 0x804 in ITOF then read 0x004 after a swap → same data (upper address bits ignored).
